// File: rtl/pl_pkg.sv
// pl_pkg
// Shared definitions for the pipeline hazard / forwarding controller.
//   - fwd_sel_e   : EX operand mux select encodings
//   - trk_entry_t : one in-flight instruction tracking entry
//   - DATA_W_DEF / REG_AW_DEF : default datapath and register-address widths
// The tracking entry stores its destination at REG_AW_MAX bits so that one
// struct type serves every legal REG_AW (1..REG_AW_MAX); narrower addresses
// are zero-extended before they are stored or compared.
package pl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int REG_AW_DEF = 2;
   localparam int REG_AW_MAX = 5;

   typedef enum logic [1:0] {
      FWD_REG  = 2'd0,
      FWD_WB   = 2'd1,
      FWD_ALU  = 2'd2,
      FWD_HOLD = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic                  valid;
      logic                  wr;
      logic                  load;
      logic [REG_AW_MAX-1:0] dest;
   } trk_entry_t;

   localparam trk_entry_t TRK_BUBBLE = '0;

endpackage

// File: rtl/pl_haz_match.sv
// pl_haz_match
// Compares one ID-stage source register against the three tracking entries
// (EX, MEM, WB) and returns the prioritised forward select plus a flag that
// says the youngest producer is a load sitting in EX.
// Ports:
//   id_valid  in   ID holds a real instruction
//   use_src   in   the instruction actually reads this source
//   src       in   zero-extended source register address
//   ex_e      in   tracking entry of the instruction in EX
//   mem_e     in   tracking entry of the instruction in MEM
//   wb_e      in   tracking entry of the instruction in WB
//   sel       out  FWD_ALU / FWD_WB / FWD_HOLD / FWD_REG
//   load_hit  out  source matches EX and EX is a load
module pl_haz_match
   import pl_pkg::*;
(
   input  logic                  id_valid,
   input  logic                  use_src,
   input  logic [REG_AW_MAX-1:0] src,
   input  trk_entry_t            ex_e,
   input  trk_entry_t            mem_e,
   input  trk_entry_t            wb_e,
   output logic [1:0]            sel,
   output logic                  load_hit
);

   logic hit_ex;
   logic hit_mem;
   logic hit_wb;

   function automatic logic entry_hit(input trk_entry_t e,
                                      input logic [REG_AW_MAX-1:0] a);
      return e.valid && e.wr && (e.dest == a);
   endfunction

   assign hit_ex  = id_valid && use_src && entry_hit(ex_e,  src);
   assign hit_mem = id_valid && use_src && entry_hit(mem_e, src);
   assign hit_wb  = id_valid && use_src && entry_hit(wb_e,  src);

   // The youngest producer wins, so EX is checked before MEM before WB.
   always_comb begin
      sel = FWD_REG;
      if (hit_ex)
         sel = FWD_ALU;
      else if (hit_mem)
         sel = FWD_WB;
      else if (hit_wb)
         sel = FWD_HOLD;
   end

   assign load_hit = hit_ex && ex_e.load;

   // Only the EX entry's load bit matters for hazard detection.
   logic unused_load;
   assign unused_load = mem_e.load ^ wb_e.load;

endmodule

// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl
// Hazard and forwarding controller for the five-stage pipeline.
// Tracks destinations of the instructions in EX, MEM and WB, registers the
// EX operand forward selects, raises load-use stalls and taken-branch
// flushes, keeps a write-back hold register and counts stall cycles.
// Build option:
//   HAZ_FWD_EN defined   : full forwarding; only load-use hazards stall.
//   HAZ_FWD_EN undefined : interlock only; any dependency on EX/MEM/WB
//                          stalls, fwd selects and wb_hold are tied to 0.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   id_valid               ID holds a real instruction
//   id_ra, id_rb           source registers in ID
//   id_use_a, id_use_b     source actually read
//   id_wr, id_wd, id_load  ID writes id_wd / is a load
//   br_taken               branch in EX is taken
//   wb_data                value being written back
//   stall, bubble          freeze front end / insert NOP into ID/EX
//   flush_if, flush_id     kill IF/ID and ID/EX
//   a_fwd_sel, b_fwd_sel   EX operand mux selects (registered)
//   wb_hold                last value written back
//   stall_count            saturating count of stall cycles
// REG_AW must not exceed pl_pkg::REG_AW_MAX.
module pl_hazard_ctrl
   import pl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic              id_wr,
   input  logic [REG_AW-1:0] id_wd,
   input  logic              id_load,
   input  logic              br_taken,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              bubble,
   output logic              flush_if,
   output logic              flush_id,
   output logic [1:0]        a_fwd_sel,
   output logic [1:0]        b_fwd_sel,
   output logic [DATA_W-1:0] wb_hold,
   output logic [CNT_W-1:0]  stall_count
);

   logic [REG_AW_MAX-1:0] ra_ext;
   logic [REG_AW_MAX-1:0] rb_ext;
   logic [REG_AW_MAX-1:0] wd_ext;
   trk_entry_t            id_entry;
   trk_entry_t            ex_q;
   trk_entry_t            mem_q;
   trk_entry_t            wb_q;
   logic [1:0]            a_sel;
   logic [1:0]            b_sel;
   logic                  a_load_hit;
   logic                  b_load_hit;
   logic                  hazard;
   logic                  kill_id;

   // Widen addresses to the package entry width and package the ID info.
   always_comb begin
      ra_ext = '0;
      rb_ext = '0;
      wd_ext = '0;
      ra_ext[REG_AW-1:0] = id_ra;
      rb_ext[REG_AW-1:0] = id_rb;
      wd_ext[REG_AW-1:0] = id_wd;
      id_entry       = TRK_BUBBLE;
      id_entry.valid = id_valid;
      id_entry.wr    = id_wr;
      id_entry.load  = id_load;
      id_entry.dest  = wd_ext;
   end

   pl_haz_match u_match_a (
      .id_valid (id_valid),
      .use_src  (id_use_a),
      .src      (ra_ext),
      .ex_e     (ex_q),
      .mem_e    (mem_q),
      .wb_e     (wb_q),
      .sel      (a_sel),
      .load_hit (a_load_hit)
   );

   pl_haz_match u_match_b (
      .id_valid (id_valid),
      .use_src  (id_use_b),
      .src      (rb_ext),
      .ex_e     (ex_q),
      .mem_e    (mem_q),
      .wb_e     (wb_q),
      .sel      (b_sel),
      .load_hit (b_load_hit)
   );

`ifdef HAZ_FWD_EN
   assign hazard = a_load_hit | b_load_hit;
`else
   // Without forwarding every in-flight dependency must drain first; a
   // non-register select is exactly "some entry matched".
   assign hazard = (a_sel != FWD_REG) | (b_sel != FWD_REG);
`endif

   // A taken branch discards the ID instruction, so it wins over a stall.
   // Reset forces every control output low at once.
   assign flush_if = br_taken & ~rst;
   assign flush_id = br_taken & ~rst;
   assign stall    = hazard & ~br_taken & ~rst;
   assign bubble   = hazard & ~br_taken & ~rst;
   assign kill_id  = stall | flush_if;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= TRK_BUBBLE;
         mem_q <= TRK_BUBBLE;
         wb_q  <= TRK_BUBBLE;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= kill_id ? TRK_BUBBLE : id_entry;
      end
   end

`ifdef HAZ_FWD_EN
   // Selects are captured as the ID instruction moves into EX; a bubble
   // carries no operands, so it gets the plain register path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_fwd_sel <= '0;
         b_fwd_sel <= '0;
      end else begin
         a_fwd_sel <= kill_id ? '0 : a_sel;
         b_fwd_sel <= kill_id ? '0 : b_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wb_hold <= '0;
      else if (wb_q.valid && wb_q.wr)
         wb_hold <= wb_data;
   end
`else
   assign a_fwd_sel = '0;
   assign b_fwd_sel = '0;
   assign wb_hold   = '0;

   logic unused_fwd;
   assign unused_fwd = ^{wb_data, a_load_hit, b_load_hit};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= '0;
      else if (stall && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb_pl_hazard_ctrl
// Self-checking bench for pl_hazard_ctrl. A per-cycle table of ID-stage
// contents carries the expected combinational outputs and the expected
// registered outputs after that cycle's edge; the registered expectations
// go into a scoreboard queue and are compared one cycle later. Hand-written
// sequences cover stall-counter saturation and reset during a stall.
// Works in both builds (HAZ_FWD_EN defined or not).
module tb_pl_hazard_ctrl;

`ifdef HAZ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = 7;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [1:0] id_ra;
   logic [1:0] id_rb;
   logic       id_use_a;
   logic       id_use_b;
   logic       id_wr;
   logic [1:0] id_wd;
   logic       id_load;
   logic       br_taken;
   logic [7:0] wb_data;
   logic       stall;
   logic       bubble;
   logic       flush_if;
   logic       flush_id;
   logic [1:0] a_fwd_sel;
   logic [1:0] b_fwd_sel;
   logic [7:0] wb_hold;
   logic [CNT_W-1:0] stall_count;

   pl_hazard_ctrl #(.DATA_W(8), .REG_AW(2), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_ra       (id_ra),
      .id_rb       (id_rb),
      .id_use_a    (id_use_a),
      .id_use_b    (id_use_b),
      .id_wr       (id_wr),
      .id_wd       (id_wd),
      .id_load     (id_load),
      .br_taken    (br_taken),
      .wb_data     (wb_data),
      .stall       (stall),
      .bubble      (bubble),
      .flush_if    (flush_if),
      .flush_id    (flush_id),
      .a_fwd_sel   (a_fwd_sel),
      .b_fwd_sel   (b_fwd_sel),
      .wb_hold     (wb_hold),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [1:0] ra;
      logic [1:0] rb;
      logic       ua;
      logic       ub;
      logic       wr;
      logic [1:0] wd;
      logic       ld;
      logic       br;
      logic [7:0] wbd;
      logic       stl;
      logic       fl;
      logic [1:0] as;
      logic [1:0] bs;
      logic [7:0] hold;
   } stim_t;

   typedef struct {
      logic [1:0] as;
      logic [1:0] bs;
      logic [7:0] hold;
      int         cnt;
   } reg_exp_t;

   reg_exp_t sb[$];
   stim_t    tbl[$];
   int       pass_cnt = 0;
   int       tot_cnt  = 0;
   int       exp_cnt  = 0;
   int       cyc      = 0;

   function automatic stim_t mk(input logic vld, input logic [1:0] ra,
      input logic [1:0] rb, input logic ua, input logic ub, input logic wr,
      input logic [1:0] wd, input logic ld, input logic br,
      input logic [7:0] wbd, input logic stl, input logic fl,
      input logic [1:0] as, input logic [1:0] bs, input logic [7:0] hold);
      stim_t s;
      s.vld = vld; s.ra = ra; s.rb = rb; s.ua = ua; s.ub = ub;
      s.wr = wr; s.wd = wd; s.ld = ld; s.br = br; s.wbd = wbd;
      s.stl = stl; s.fl = fl; s.as = as; s.bs = bs; s.hold = hold;
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      tot_cnt++;
      if (actual === expected)
         pass_cnt++;
      else
         $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                  name, cyc, actual, expected);
   endtask

   // Compare registered outputs against the oldest scoreboard entry.
   task automatic drainCheck();
      reg_exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("a_fwd_sel", 16'(a_fwd_sel), 16'(e.as));
         checkOutput("b_fwd_sel", 16'(b_fwd_sel), 16'(e.bs));
         checkOutput("wb_hold", 16'(wb_hold), 16'(e.hold));
         checkOutput("stall_count", 16'(stall_count), 16'(e.cnt));
      end
   endtask

   // One pipeline cycle: check last edge's results, drive ID, check the
   // combinational outputs, queue what the next edge should produce.
   task automatic applyStimulus(input stim_t s);
      reg_exp_t e;
      @(negedge clk);
      cyc++;
      drainCheck();
      id_valid = s.vld; id_ra = s.ra; id_rb = s.rb;
      id_use_a = s.ua; id_use_b = s.ub; id_wr = s.wr; id_wd = s.wd;
      id_load = s.ld; br_taken = s.br; wb_data = s.wbd;
      #1;
      checkOutput("stall", 16'(stall), 16'(s.stl));
      checkOutput("bubble", 16'(bubble), 16'(s.stl));
      checkOutput("flush_if", 16'(flush_if), 16'(s.fl));
      checkOutput("flush_id", 16'(flush_id), 16'(s.fl));
      if (s.stl)
         exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      e.as = s.as; e.bs = s.bs; e.hold = s.hold; e.cnt = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_stall"}, 16'(stall), 16'd0);
      checkOutput({tag, "_bubble"}, 16'(bubble), 16'd0);
      checkOutput({tag, "_flush_if"}, 16'(flush_if), 16'd0);
      checkOutput({tag, "_flush_id"}, 16'(flush_id), 16'd0);
      checkOutput({tag, "_a_fwd_sel"}, 16'(a_fwd_sel), 16'd0);
      checkOutput({tag, "_b_fwd_sel"}, 16'(b_fwd_sel), 16'd0);
      checkOutput({tag, "_wb_hold"}, 16'(wb_hold), 16'd0);
      checkOutput({tag, "_stall_count"}, 16'(stall_count), 16'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] hold_end;
      int         spp;
      logic [1:0] rel_sel;

      rst = 1'b1;
      id_valid = 0; id_ra = 0; id_rb = 0; id_use_a = 0; id_use_b = 0;
      id_wr = 0; id_wd = 0; id_load = 0; br_taken = 0; wb_data = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

`ifdef HAZ_FWD_EN
      // vld ra rb ua ub wr wd ld br  wbd  stl fl as bs hold
      tbl.push_back(mk(1,0,0,0,0,1,1,0,0,8'hEE,0,0,0,0,8'h00)); // P wr r1
      tbl.push_back(mk(1,1,3,1,1,0,0,0,0,8'hEE,0,0,2,0,8'h00)); // rd r1: ALU
      tbl.push_back(mk(1,0,0,0,0,1,3,0,0,8'hEE,0,0,0,0,8'h00)); // P wr r3
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,8'h11,0,0,0,0,8'h11)); // indep
      tbl.push_back(mk(1,0,3,0,1,0,0,0,0,8'hEE,0,0,0,1,8'h11)); // rd r3: WB
      tbl.push_back(mk(1,0,0,0,0,1,2,0,0,8'h33,0,0,0,0,8'h33)); // P wr r2
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,8'hEE,0,0,0,0,8'h33)); // indep
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,8'hEE,0,0,0,0,8'h33)); // indep
      tbl.push_back(mk(1,2,0,1,0,0,0,0,0,8'hA5,0,0,3,0,8'hA5)); // rd r2: HOLD
      tbl.push_back(mk(1,0,0,0,0,1,2,1,0,8'hEE,0,0,0,0,8'hA5)); // load r2
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,1,0,0,0,8'hA5)); // load-use
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,0,0,0,1,8'hA5)); // advances
      tbl.push_back(mk(1,0,0,0,0,1,1,1,0,8'h5C,0,0,0,0,8'h5C)); // load r1
      tbl.push_back(mk(1,1,0,1,0,0,0,0,1,8'hEE,0,1,0,0,8'h5C)); // hazard+br
      tbl.push_back(mk(0,1,0,1,0,0,0,0,0,8'hEE,0,0,0,0,8'h5C)); // invalid ID
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,8'h77,0,1,0,0,8'h77)); // flush
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,8'hEE,0,1,0,0,8'h77)); // flush again
`else
      tbl.push_back(mk(1,0,0,0,0,1,1,0,0,8'hEE,0,0,0,0,8'h00)); // P wr r1
      tbl.push_back(mk(1,1,3,1,1,0,0,0,0,8'hEE,1,0,0,0,8'h00)); // dep in EX
      tbl.push_back(mk(1,1,3,1,1,0,0,0,0,8'hEE,1,0,0,0,8'h00)); // dep in MEM
      tbl.push_back(mk(1,1,3,1,1,0,0,0,0,8'hEE,1,0,0,0,8'h00)); // dep in WB
      tbl.push_back(mk(1,1,3,1,1,0,0,0,0,8'hEE,0,0,0,0,8'h00)); // advances
      tbl.push_back(mk(1,0,0,0,0,1,2,1,0,8'hEE,0,0,0,0,8'h00)); // load r2
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,1,0,0,0,8'h00));
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,1,0,0,0,8'h00));
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,1,0,0,0,8'h00));
      tbl.push_back(mk(1,0,2,0,1,0,0,0,0,8'hEE,0,0,0,0,8'h00));
      tbl.push_back(mk(1,0,0,0,0,1,1,1,0,8'hEE,0,0,0,0,8'h00)); // load r1
      tbl.push_back(mk(1,1,0,1,0,0,0,0,1,8'hEE,0,1,0,0,8'h00)); // hazard+br
      tbl.push_back(mk(0,1,0,1,0,0,0,0,0,8'hEE,0,0,0,0,8'h00)); // invalid ID
      tbl.push_back(mk(1,1,0,1,0,0,0,0,1,8'hEE,0,1,0,0,8'h00)); // hazard+br
      tbl.push_back(mk(1,1,0,1,0,0,0,0,0,8'hEE,0,0,0,0,8'h00)); // drained
`endif
      for (int i = 0; i < tbl.size(); i++)
         applyStimulus(tbl[i]);

      // Repeated load/consumer pairs drive the 3-bit counter into saturation.
      hold_end = FWD ? 8'h77 : 8'h00;
      spp      = FWD ? 1 : 3;
      rel_sel  = FWD ? 2'd1 : 2'd0;
      for (int p = 0; p < 8; p++) begin
         applyStimulus(mk(1,0,0,0,0,1,3,1,0,8'h77,0,0,0,0,hold_end));
         for (int k = 0; k < spp; k++)
            applyStimulus(mk(1,3,0,1,0,0,0,0,0,8'h77,1,0,0,0,hold_end));
         applyStimulus(mk(1,3,0,1,0,0,0,0,0,8'h77,0,0,rel_sel,0,hold_end));
      end

      // Reset asserted in the middle of a stall cycle.
      applyStimulus(mk(1,0,0,0,0,1,2,1,0,8'h77,0,0,0,0,hold_end));
      applyStimulus(mk(1,0,2,0,1,0,0,0,0,8'h77,1,0,0,0,hold_end));
      drainCheck();
      checkOutput("pre_reset_count", 16'(stall_count), 16'(CNT_MAX));
      rst = 1'b1;
      #1;
      sb.delete();
      exp_cnt = 0;
      checkAllZero("mid_reset");
      @(posedge clk);
      #1;
      checkAllZero("held_reset");
      rst = 1'b0;
      applyStimulus(mk(1,0,2,0,1,0,0,0,0,8'h77,0,0,0,0,8'h00));
      applyStimulus(mk(0,0,0,0,0,0,0,0,0,8'h77,0,0,0,0,8'h00));
      @(negedge clk);
      drainCheck();

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/pl_hazard_ctrl.md
# pl_hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage pipelined RISC core (IF, ID, EX, MEM, WB). It tracks the destination registers of in-flight instructions and produces registered forwarding selects for the EX-stage operand muxes. It also generates load-use stalls and taken-branch flushes, and keeps a write-back hold register so that a value retiring in WB can still be forwarded.

## Interface
- DATA_W, 8, datapath width; sets the width of wb_data and wb_hold.
- REG_AW, 2, register address width; the register file has 2^REG_AW entries.
- CNT_W, 16, width of the saturating stall-cycle counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_ra, id_rb  in  REG_AW  source register addresses in ID.
- id_use_a, id_use_b  in  1  the instruction in ID reads ra / rb.
- id_wr  in  1  the instruction in ID writes a register.
- id_wd  in  REG_AW  destination register of the instruction in ID.
- id_load  in  1  the instruction in ID is a data-memory load.
- br_taken  in  1  the branch in EX is taken (from the branch controller).
- wb_data  in  DATA_W  result currently being written back.
- stall  out  1  freeze PC and the IF/ID register.
- bubble  out  1  load a NOP into the ID/EX register.
- flush_if, flush_id  out  1  kill the IF/ID and ID/EX contents.
- a_fwd_sel, b_fwd_sel  out  2  EX operand mux select: 0 = register, 1 = wb_data, 2 = ALU_EX, 3 = wb_hold.
- wb_hold  out  DATA_W  last value written back.
- stall_count  out  CNT_W  number of stall cycles.

## Operation
- Tracking: three entries ex_q, mem_q, wb_q, each holding {valid, wr, load, dest}.
  - Every cycle: wb_q <= mem_q and mem_q <= ex_q.
  - ex_q <= ID info when there is no stall and no flush; otherwise ex_q is loaded with a bubble (valid = 0).
- Source match: a source S in ID matches an entry E when all of the following hold: id_valid, use_S, E.valid, E.wr, and E.dest equals the address of S.
- Load-use hazard: some used source matches ex_q and ex_q.load = 1.
  - Response: stall = bubble = 1 for exactly one cycle.
- Forward select, computed for the instruction in ID and registered into the fwd_sel outputs on the edge where it enters EX. Priority order:
  - match ex_q gives code 2;
  - else match mem_q gives code 1;
  - else match wb_q gives code 3;
  - else code 0.
- When the ID instruction is replaced by a bubble, both fwd_sel outputs register 0.
- Hold register: wb_hold <= wb_data on every edge where wb_q.valid && wb_q.wr.
- Branch: br_taken = 1 gives flush_if = flush_id = 1 in the same cycle.
  - Flush overrides stall: stall = 0 and bubble = 0 that cycle.
  - ex_q receives a bubble.
- stall_count increments on each cycle with stall = 1 and saturates at all-ones.
- Mid-operation reset clears all state immediately, regardless of any pending stall or flush.

## Timing
- Reset values: stall, bubble, flush_if, flush_id = 0; a_fwd_sel, b_fwd_sel = 0; wb_hold = 0; stall_count = 0; all tracking entries invalid.
- stall, bubble and flush_* are combinational from the current ID inputs, br_taken and the tracking entries (zero latency).
- fwd_sel outputs have one-cycle latency: they are valid during the cycle the consumer is in EX.
- Load-use sequence: cycle N shows the hazard with stall = 1. In cycle N+1 the load is in MEM, the hazard has cleared, and the consumer advances. In cycle N+2 the consumer is in EX with fwd_sel = 1.
- Back-to-back flushes are each honoured independently; there is no hidden state.

## Configuration
- HAZ_FWD_EN defined: full forwarding exactly as described above.
- HAZ_FWD_EN undefined: interlock-only operation.
  - stall = bubble = 1 while any used source matches ex_q, mem_q or wb_q.
  - Both fwd_sel outputs are constant 0, and wb_hold is constant 0.
  - Branch flush behaviour and stall_count behave the same as with forwarding.

## Structure
- Shared package pl_pkg holds:
  - the fwd_sel encodings FWD_REG, FWD_WB, FWD_ALU, FWD_HOLD;
  - the typedef of a tracking entry;
  - defaults for DATA_W and REG_AW.
- One sub-module, pl_haz_match: the combinational comparison of one source address against the three tracking entries. It returns the encoded select and a load-hit flag, and is instantiated twice (sources a and b).

## Test plan
- Two ALU ops back to back, producer writes r1 and consumer reads r1 as ra -> no stall; a_fwd_sel = 2 while the consumer is in EX.
- Producer, one independent op, then the consumer -> b_fwd_sel = 1. With two intervening ops -> sel = 3, and wb_hold equals the value written (e.g. 0xA5).
- Load r2, then consumer reads r2 -> exactly one cycle with stall = bubble = 1; next the consumer sees fwd_sel = 1; stall_count = 1.
- br_taken asserted in the same cycle as a load-use hazard -> flush_if = flush_id = 1 and stall = 0; the flushed consumer never gets a nonzero fwd_sel.
- Build without HAZ_FWD_EN, dependent pair -> stall held for 3 cycles; fwd_sel stays 0.
- Assert rst during a stall -> all outputs go to 0 immediately; the first instruction after reset has no stale matches.
